seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Serial bit-stream pattern detector, runtime-programmable pattern of 1..MAX_LEN bits.
- Selectable overlapping / non-overlapping detection; qualified input (x_valid); saturating match counter.
- Next-generation replacement for the fixed 1011 detector.
- Reset defaults reproduce the fixed-1011 overlapping behaviour exactly, so it drops into existing FSM-lab tops.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (>= 2).
- LEN_W, $clog2(MAX_LEN+1): width of the length field.
- CNT_W, 8: width of match_count.

Ports:
- clock  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe; latch cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first received bit, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- x_valid  input  1  x is sampled only when high.
- x  input  1  serial data bit.
- y  output  1  registered one-cycle match pulse.
- match_count  output  CNT_W  saturating count of y pulses.

Behaviour:
- Reset (synchronous):
  - hist = 0, fill = 0, y = 0, match_count = 0.
  - pat = 4'b1011 zero-extended, len = 4, overlap = 1.
- Internal state:
  - hist[MAX_LEN-1:0] shift register.
  - fill = valid bits since last clear, saturating at MAX_LEN.
  - pat, len, overlap configuration registers.
- Shift on x_valid (and not cfg_load): hist <= {hist[MAX_LEN-2:0], x}; fill <= min(fill+1, MAX_LEN).
- Match condition: x_valid, len != 0, the len LSBs of the shifted hist equal the len LSBs of pat, and fill+1 >= len.
- Output timing:
  - y <= match, so y is high exactly in the cycle after the completing x_valid cycle.
  - Otherwise y <= 0; y never stays high for 2 cycles without 2 matching valid bits.
- Overlap mode: fill is unaffected by a match; the suffix of the matched bits may start the next match.
- Non-overlap mode: on a match, fill <= 0; hist still shifts, but the next match needs len fresh bits.
- x_valid = 0: hist, fill and configuration hold; y <= 0.
- cfg_load:
  - Next cycle: pat/len/overlap take the new values; hist = 0, fill = 0, y = 0, match_count = 0.
  - If it coincides with x_valid, cfg_load wins and x is dropped.
- Length edge cases:
  - cfg_len > MAX_LEN is clamped to MAX_LEN at load.
  - cfg_len = 0 disables detection; y stays 0.
- len = 1: every valid bit equal to pat[0] matches in either mode.
- match_count: increments when y is set; holds at 2^CNT_W-1 (no wrap).
- reset asserted mid-stream: all state returns to reset values next cycle, including configuration; a partial match is discarded.

Optional Feature:
- Macro: SEQ_DETECTOR_PARAM_COUNT_EN.
- Defined: the match_count register and its saturation logic are built as described.
- Undefined: the counter is not synthesised; match_count is driven constant 0; all other behaviour is identical.

Decomposition:
- Package seq_det_pkg holds:
  - SEQ_DET_DEFAULT_PATTERN (8'b0000_1011) and SEQ_DET_DEFAULT_LEN (4).
  - A function returning the masked compare of hist and pat for a given len.
- One natural sub-module: seq_det_sat_counter (CNT_W, inc, clr -> saturating count).
  - Instantiated only under SEQ_DETECTOR_PARAM_COUNT_EN.

Test Plan:
- Legacy defaults: after reset, stream 1,0,1,1,0,1,1 all valid -> y pulses after bit 4 and bit 7 (overlap); match_count = 2.
- Non-overlap: cfg_load pattern 3'b111, len 3, overlap 0; stream 1 x6 -> y after bits 3 and 6 only; match_count = 2.
- Gaps: pattern 1011 with x_valid low for 3 cycles between bits 2 and 3 -> single y one cycle after the 4th valid bit; y is 0 during the gaps.
- Collision: cfg_load with x_valid = 1 and x = 1 in the same cycle -> bit is ignored, fill = 0, no spurious y; new pattern 8'hA5, len 8 matches only after 8 fresh bits.
- Edges: len 0 -> y never asserts over 32 random bits; cfg_len = 15 with MAX_LEN = 8 -> behaves as len 8; len 1 with pat[0] = 0 -> y follows each valid 0.
- Saturation/reset: CNT_W = 2, 5 matches -> match_count holds 3; reset mid-pattern after 1,0,1 then 1 -> no y.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and masked pattern compare for seq_detector_param
//   SEQ_DET_DEFAULT_PATTERN / SEQ_DET_DEFAULT_LEN : legacy 1011 detector configuration
//   seq_det_masked_eq(a, b, len)                  : 1 when the len LSBs of a and b agree
package seq_det_pkg;
   localparam logic [7:0] SEQ_DET_DEFAULT_PATTERN = 8'b0000_1011;
   localparam int         SEQ_DET_DEFAULT_LEN     = 4;
   // Compare width; callers zero-extend, so MAX_LEN must not exceed this.
   localparam int         SEQ_DET_FN_W            = 32;

   function automatic logic seq_det_masked_eq(
      input logic [SEQ_DET_FN_W-1:0] a,
      input logic [SEQ_DET_FN_W-1:0] b,
      input logic [SEQ_DET_FN_W-1:0] len
   );
      logic [SEQ_DET_FN_W-1:0] mask;
      mask = (len >= SEQ_DET_FN_W) ? '1 : ((SEQ_DET_FN_W'(1) << len) - SEQ_DET_FN_W'(1));
      return ((a ^ b) & mask) == '0;
   endfunction
endpackage

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter: saturating event counter
//   clock, reset : posedge clock, synchronous active-high reset
//   i_clr        : synchronous clear
//   i_inc        : count one event, holding at all-ones
//   o_count      : current count
module seq_det_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clock) begin
      if (reset || i_clr) r_count <= '0;
      else if (i_inc && r_count != '1) r_count <= r_count + CNT_W'(1);
   end

   assign o_count = r_count;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector (1..MAX_LEN bits)
//   clock, reset   : posedge clock, synchronous active-high reset (restores legacy 1011 overlap)
//   cfg_load       : strobe latching cfg_pattern / cfg_len (clamped to MAX_LEN) / cfg_overlap
//   x_valid, x     : qualified serial input; bit [len-1] of the pattern is received first
//   y              : registered one-cycle match pulse
//   match_count    : saturating count of y pulses, built only with SEQ_DETECTOR_PARAM_COUNT_EN
//                    (constant 0 otherwise)
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               x_valid,
   input  logic               x,
   output logic               y,
   output logic [CNT_W-1:0]   match_count
);
   logic [MAX_LEN-1:0] r_hist;
   logic [MAX_LEN-1:0] r_pat;
   logic [LEN_W-1:0]   r_fill;
   logic [LEN_W-1:0]   r_len;
   logic               r_overlap;
   logic               r_y;

   logic [MAX_LEN-1:0] w_hist_next;
   logic [LEN_W:0]     w_fill_inc;
   logic [LEN_W-1:0]   w_fill_sat;
   logic [LEN_W-1:0]   w_cfg_len;
   logic               w_match;

   always_comb begin
      w_hist_next = {r_hist[MAX_LEN-2:0], x};
      w_fill_inc  = {1'b0, r_fill} + (LEN_W + 1)'(1);
      w_fill_sat  = (w_fill_inc >= (LEN_W + 1)'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_fill_inc[LEN_W-1:0];
      w_cfg_len   = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      // fill counts bits since the last clear, so fill+1 >= len means every compared
      // history bit was received after that clear.
      w_match     = x_valid && !cfg_load && (r_len != '0)
                    && (w_fill_inc >= {1'b0, r_len})
                    && seq_det_masked_eq(SEQ_DET_FN_W'(w_hist_next), SEQ_DET_FN_W'(r_pat),
                                         SEQ_DET_FN_W'(r_len));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
         r_pat     <= MAX_LEN'(SEQ_DET_DEFAULT_PATTERN);
         r_len     <= LEN_W'(SEQ_DET_DEFAULT_LEN);
         r_overlap <= 1'b1;
      end else if (cfg_load) begin
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
         r_pat     <= cfg_pattern;
         r_len     <= w_cfg_len;
         r_overlap <= cfg_overlap;
      end else begin
         r_y <= w_match;
         if (x_valid) begin
            r_hist <= w_hist_next;
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_sat;
         end
      end
   end

   assign y = r_y;

`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
   seq_det_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .i_clr   (cfg_load),
      .i_inc   (w_match),
      .o_count (match_count)
   );
`else
   assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: randomized scoreboard bench for seq_detector_param against a bit-list model
module tb_seq_detector_param;
   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               x_valid = 1'b0;
   logic               x = 1'b0;
   logic               y;
   logic [CNT_W-1:0]   match_count;

   always #5 clock = ~clock;

   seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .x_valid     (x_valid),
      .x           (x),
      .y           (y),
      .match_count (match_count)
   );

   typedef struct {
      logic             y;
      logic [CNT_W-1:0] cnt;
      int               step;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   // Reference model: the list of valid bits received since the last clear.
   bit               m_bits[$];
   logic [MAX_LEN-1:0] m_pat;
   int               m_len;
   bit               m_ov;
   int               m_cnt;

   task automatic drive(input bit rst, input bit ld, input logic [MAX_LEN-1:0] p, input int l,
                        input bit ov, input bit xv, input bit xb);
      exp_t e;
      bit   hit;
      @(negedge clock);
      reset = rst; cfg_load = ld; cfg_pattern = p; cfg_len = LEN_W'(l);
      cfg_overlap = ov; x_valid = xv; x = xb;
      hit = 1'b0;
      if (rst) begin
         m_bits.delete(); m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1; m_cnt = 0;
      end else if (ld) begin
         m_bits.delete(); m_pat = p; m_len = (l > MAX_LEN) ? MAX_LEN : l; m_ov = ov; m_cnt = 0;
      end else if (xv) begin
         m_bits.push_back(xb);
         if (m_len != 0 && m_bits.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (m_bits[m_bits.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
         end
         if (hit) begin
            if (m_cnt < 2**CNT_W - 1) m_cnt++;
            if (!m_ov) m_bits.delete();
         end
         if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
      end
      e.y = hit;
`ifdef SEQ_DETECTOR_PARAM_COUNT_EN
      e.cnt = CNT_W'(m_cnt);
`else
      e.cnt = '0;
`endif
      e.step = step_no++;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      drive(1, 0, '0, 0, 0, 0, 0);
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input int l, input bit ov);
      drive(0, 1, p, l, ov, 0, 0);
   endtask

   task automatic bit_in(input bit b);
      drive(0, 0, '0, 0, 0, 1, b);
   endtask

   task automatic idle();
      drive(0, 0, '0, 0, 0, 0, 0);
   endtask

   exp_t me;
   always @(posedge clock) begin
      #1;
      if (sb.size() > 0) begin
         me = sb.pop_front();
         checks += 2;
         if (y !== me.y) begin
            errors++;
            $display("FAIL y step %0d: got %b want %b", me.step, y, me.y);
         end
         if (match_count !== me.cnt) begin
            errors++;
            $display("FAIL match_count step %0d: got %0d want %0d", me.step, match_count, me.cnt);
         end
      end
   end

   initial begin
      bit legacy[7] = '{1, 0, 1, 1, 0, 1, 1};
      do_reset();
      foreach (legacy[i]) bit_in(legacy[i]);
      idle();
      load(8'b0000_0111, 3, 0);
      repeat (6) bit_in(1);
      idle();
      do_reset();
      bit_in(1); bit_in(0);
      repeat (3) idle();
      bit_in(1); bit_in(1);
      idle();
      drive(0, 1, 8'hA5, 8, 1, 1, 1);
      for (int i = 7; i >= 0; i--) bit_in(8'hA5 >> i & 1);
      for (int i = 7; i >= 0; i--) bit_in(8'hA5 >> i & 1);
      load(8'h00, 0, 1);
      repeat (32) bit_in($urandom_range(0, 1));
      load(8'hFF, 15, 0);
      repeat (20) bit_in(1);
      load(8'hFE, 1, 1);
      repeat (12) begin
         if ($urandom_range(0, 3) == 0) idle(); else bit_in($urandom_range(0, 1));
      end
      load(8'h01, 1, 0);
      repeat (7) bit_in(1);
      do_reset();
      bit_in(1); bit_in(0); bit_in(1);
      do_reset();
      bit_in(1);
      idle();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) do_reset();
         else load(MAX_LEN'($urandom), $urandom_range(0, 15), $urandom_range(0, 1));
         repeat (40) begin
            case ($urandom_range(0, 9))
               0:       idle();
               1:       drive(0, 1, MAX_LEN'($urandom), $urandom_range(0, 4), $urandom_range(0, 1), 1, 1);
               default: bit_in($urandom_range(0, 1));
            endcase
         end
      end
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
